// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one 4:1 select path.
// It registers a one-hot grant plus the matching select, and limits bursts.
//
// Ports:
//   clk   in  1  clock, rising edge
//   rst_n in  1  asynchronous active-low reset
//   req   in  4  request per requester (bit i = requester i)
//   lock  in  1  present only when ARB_LOCK_EN is defined; owner keeps path
//   gnt   out 4  registered one-hot grant, zero when idle
//   sel   out 2  registered index of the grant owner, held while idle
//   busy  out 1  registered, equals |gnt
//
// Optional feature macro: ARB_LOCK_EN (adds the lock input).
module mux_rr_arbiter #(
    parameter int unsigned BURST_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
`ifdef ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_OWN  = 1'b1
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(BURST_MAX - 1);

    state_t     r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_sel;
    logic       r_busy;
    logic [1:0] r_ptr;
    logic [7:0] r_cnt;

    state_t     w_state_nxt;
    logic [3:0] w_gnt_nxt;
    logic [1:0] w_sel_nxt;
    logic [1:0] w_ptr_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_grant;
    logic [1:0] w_win;
    logic [2:0] w_pick_all;
    logic [2:0] w_pick_oth;
    logic       w_own_req;
    logic       w_lock;

    // Returns {found, index}; search order ptr+1, ptr+2, ptr+3, ptr.
    function automatic logic [2:0] f_pick(
        input logic [3:0] i_r,
        input logic [1:0] i_p
    );
        logic [2:0] v;
        logic [1:0] idx;
        v = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = i_p + 2'(k);
            if (!v[2] && i_r[idx]) begin
                v = {1'b1, idx};
            end
        end
        return v;
    endfunction

    // Ptr always equals the owner while in OWN, so masking the owner out
    // yields the forced-release winner.
    assign w_pick_all = f_pick(req, r_ptr);
    assign w_pick_oth = f_pick(req & ~r_gnt, r_ptr);
    assign w_own_req  = |(req & r_gnt);

`ifdef ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_grant     = 1'b0;
        w_win       = 2'd0;
        unique case (r_state)
            S_IDLE: begin
                if (w_pick_all[2]) begin
                    w_grant = 1'b1;
                    w_win   = w_pick_all[1:0];
                end
            end
            S_OWN: begin
                if (!w_own_req) begin
                    // Release; hand straight over when anyone else waits.
                    if (w_pick_all[2]) begin
                        w_grant = 1'b1;
                        w_win   = w_pick_all[1:0];
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else if (w_lock) begin
                    // Locked owner: count saturates, limit not applied.
                    if (r_cnt < CNT_MAX) begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end else if (r_cnt < CNT_MAX) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end else if (w_pick_oth[2]) begin
                    w_grant = 1'b1;
                    w_win   = w_pick_oth[1:0];
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_grant) begin
            w_state_nxt = S_OWN;
            w_gnt_nxt   = 4'b0001 << w_win;
            w_sel_nxt   = w_win;
            w_ptr_nxt   = w_win;
            w_cnt_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= 2'd3;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_busy  <= |w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = r_busy;

endmodule
